// File: rtl/writeback_stage_if.sv
// M-to-W bundle for the writeback stage: hazard controls, M-stage results in, register-file write port out.
interface writeback_stage_if #(
  parameter int COUNT_WIDTH = 32
);
  logic                   stall;
  logic                   flush;
  logic                   valid_m;
  logic                   reg_write_m;
  logic                   mem_to_reg_m;
  logic [2:0]             load_type_m;
  logic [1:0]             byte_offset_m;
  logic [4:0]             write_address_m;
  logic [31:0]            alu_result_m;
  logic [31:0]            mem_read_data_m;
  logic [31:0]            rt_value_m;
  logic                   write_enable;
  logic [4:0]             write_address;
  logic [31:0]            write_data;
  logic                   valid_w;
  logic                   address_error_w;
  logic [COUNT_WIDTH-1:0] retired_count;

  modport master (
    output stall, flush, valid_m, reg_write_m, mem_to_reg_m, load_type_m,
           byte_offset_m, write_address_m, alu_result_m, mem_read_data_m, rt_value_m,
    input  write_enable, write_address, write_data, valid_w, address_error_w, retired_count
  );

  modport slave (
    input  stall, flush, valid_m, reg_write_m, mem_to_reg_m, load_type_m,
           byte_offset_m, write_address_m, alu_result_m, mem_read_data_m, rt_value_m,
    output write_enable, write_address, write_data, valid_w, address_error_w, retired_count
  );
endinterface

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register: formats big-endian load data in M, registers it, and drives
// the register-file write port straight from flops. Also counts retired instructions.
module writeback_stage #(
  parameter int COUNT_WIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  writeback_stage_if.slave  wb
);

  localparam logic [2:0] LT_LB  = 3'd1;
  localparam logic [2:0] LT_LBU = 3'd2;
  localparam logic [2:0] LT_LH  = 3'd3;
  localparam logic [2:0] LT_LHU = 3'd4;
  localparam logic [2:0] LT_LWL = 3'd5;
  localparam logic [2:0] LT_LWR = 3'd6;

  function automatic logic is_misaligned(input logic [2:0] lt, input logic [1:0] off);
    logic mis;
    case (lt)
      LT_LB, LT_LBU, LT_LWL, LT_LWR: mis = 1'b0;
      LT_LH, LT_LHU:                 mis = off[0];
      default:                       mis = (off != 2'd0);
    endcase
    return mis;
  endfunction

  // Byte 0 is the most significant lane (big-endian).
  function automatic logic [31:0] format_load(input logic [2:0]  lt,
                                              input logic [1:0]  off,
                                              input logic [31:0] mem,
                                              input logic [31:0] rt);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = mem[31:24];
      2'd1:    b = mem[23:16];
      2'd2:    b = mem[15:8];
      default: b = mem[7:0];
    endcase
    h = off[1] ? mem[15:0] : mem[31:16];
    case (lt)
      LT_LB:  r = {{24{b[7]}}, b};
      LT_LBU: r = {24'd0, b};
      LT_LH:  r = {{16{h[15]}}, h};
      LT_LHU: r = {16'd0, h};
      LT_LWL:
        case (off)
          2'd0:    r = mem;
          2'd1:    r = {mem[23:0], rt[7:0]};
          2'd2:    r = {mem[15:0], rt[15:0]};
          default: r = {mem[7:0],  rt[23:0]};
        endcase
      LT_LWR:
        case (off)
          2'd0:    r = {rt[31:8],  mem[31:24]};
          2'd1:    r = {rt[31:16], mem[31:16]};
          2'd2:    r = {rt[31:24], mem[31:8]};
          default: r = mem;
        endcase
      default: r = mem;
    endcase
    return r;
  endfunction

  logic                   aerr_m;
  logic [31:0]            result_m;
  logic                   we_m;

  logic                   valid_q,  valid_d;
  logic                   aerr_q,   aerr_d;
  logic                   we_q,     we_d;
  logic [4:0]             addr_q,   addr_d;
  logic [31:0]            data_q,   data_d;
  logic [COUNT_WIDTH-1:0] count_q,  count_d;

  assign aerr_m   = wb.valid_m & wb.mem_to_reg_m & is_misaligned(wb.load_type_m, wb.byte_offset_m);
  assign result_m = wb.mem_to_reg_m
                  ? format_load(wb.load_type_m, wb.byte_offset_m, wb.mem_read_data_m, wb.rt_value_m)
                  : wb.alu_result_m;
  // write_enable is precomputed so every W output is a bare flop.
  assign we_m     = wb.valid_m & wb.reg_write_m & ~aerr_m & (wb.write_address_m != 5'd0);

  always_comb begin
    valid_d = valid_q;
    aerr_d  = aerr_q;
    we_d    = we_q;
    addr_d  = addr_q;
    data_d  = data_q;
    count_d = count_q;
    if (wb.flush) begin
      valid_d = 1'b0;
      aerr_d  = 1'b0;
      we_d    = 1'b0;
      addr_d  = 5'd0;
      data_d  = 32'd0;
    end else if (!wb.stall) begin
      valid_d = wb.valid_m;
      aerr_d  = aerr_m;
      we_d    = we_m;
      addr_d  = wb.write_address_m;
      data_d  = result_m;
      if (wb.valid_m && !aerr_m)
        count_d = count_q + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      aerr_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 5'd0;
      data_q  <= 32'd0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      aerr_q  <= aerr_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  assign wb.valid_w         = valid_q;
  assign wb.address_error_w = aerr_q;
  assign wb.write_enable    = we_q;
  assign wb.write_address   = addr_q;
  assign wb.write_data      = data_q;
  assign wb.retired_count   = count_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: directed cases plus random traffic against a reference model,
// with expectations queued by the driver and checked by an independent monitor.
module tb_writeback_stage;
  localparam int CW = 8;

  logic clk;
  logic reset;
  int   cyc;
  int   checks;
  int   errors;

  writeback_stage_if #(.COUNT_WIDTH(CW)) wb ();
  writeback_stage #(.COUNT_WIDTH(CW)) dut (.clk(clk), .reset(reset), .wb(wb));

  typedef struct {
    int              cyc;
    logic            valid;
    logic            aerr;
    logic            we;
    logic            known;
    logic [4:0]      addr;
    logic [31:0]     data;
    logic [CW-1:0]   cnt;
  } exp_t;

  exp_t q[$];

  logic          m_valid, m_aerr, m_we, m_known;
  logic [4:0]    m_addr;
  logic [31:0]   m_data;
  logic [CW-1:0] m_cnt;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic mtr, input logic [2:0] lt, input int k,
                                             input logic [31:0] mem, input logic [31:0] rt,
                                             input logic [31:0] alu);
    logic [31:0] v;
    if (!mtr) return alu;
    case (lt)
      3'd1: begin v = (mem >> (8*(3-k))) & 32'hFF;   return v[7]  ? (v | 32'hFFFFFF00) : v; end
      3'd2: return (mem >> (8*(3-k))) & 32'hFF;
      3'd3: begin v = (mem >> (8*(2-k))) & 32'hFFFF; return v[15] ? (v | 32'hFFFF0000) : v; end
      3'd4: return (mem >> (8*(2-k))) & 32'hFFFF;
      3'd5: return (mem << (8*k)) | (rt & ((32'd1 << (8*k)) - 32'd1));
      3'd6: return (mem >> (8*(3-k))) | (rt & ~(32'hFFFFFFFF >> (8*(3-k))));
      default: return mem;
    endcase
  endfunction

  function automatic logic ref_misaligned(input logic [2:0] lt, input int k);
    if (lt == 3'd3 || lt == 3'd4) return (k % 2) != 0;
    if (lt == 3'd0 || lt == 3'd7) return k != 0;
    return 1'b0;
  endfunction

  // Apply one M-stage cycle, advance the model, queue the expected W state, then cross the edge.
  task automatic step(input logic v, input logic rw, input logic mtr, input logic [2:0] lt,
                      input logic [1:0] off, input logic [4:0] wa, input logic [31:0] alu,
                      input logic [31:0] mem, input logic [31:0] rt, input logic st, input logic fl);
    exp_t e;
    logic mis;
    wb.valid_m = v;  wb.reg_write_m = rw;  wb.mem_to_reg_m = mtr;  wb.load_type_m = lt;
    wb.byte_offset_m = off;  wb.write_address_m = wa;  wb.alu_result_m = alu;
    wb.mem_read_data_m = mem;  wb.rt_value_m = rt;  wb.stall = st;  wb.flush = fl;
    if (fl) begin
      m_valid = 1'b0; m_aerr = 1'b0; m_we = 1'b0; m_known = 1'b0;
    end else if (!st) begin
      mis     = v && mtr && ref_misaligned(lt, int'(off));
      m_valid = v;
      m_aerr  = mis;
      m_addr  = wa;
      m_data  = ref_result(mtr, lt, int'(off), mem, rt, alu);
      m_we    = v && rw && !mis && (wa != 5'd0);
      m_known = 1'b1;
      if (v && !mis) m_cnt = m_cnt + 1'b1;
    end
    e.cyc = cyc + 1; e.valid = m_valid; e.aerr = m_aerr; e.we = m_we; e.known = m_known;
    e.addr = m_addr; e.data = m_data; e.cnt = m_cnt;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_aerr = 1'b0; m_we = 1'b0; m_known = 1'b1;
    m_addr = 5'd0; m_data = 32'd0; m_cnt = '0;
  endtask

  task automatic alu_op(input logic [4:0] wa, input logic [31:0] val);
    step(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, wa, val, $urandom, $urandom, 1'b0, 1'b0);
  endtask

  task automatic load_op(input logic [2:0] lt, input logic [1:0] off, input logic [31:0] mem,
                         input logic [31:0] rt);
    step(1'b1, 1'b1, 1'b1, lt, off, 5'd7, $urandom, mem, rt, 1'b0, 1'b0);
  endtask

  // Monitor: compare every queued expectation at the negedge of the cycle it targets.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc < cyc) begin
      chk("sb_stale", 32'(q[0].cyc), 32'(cyc));
      void'(q.pop_front());
    end
    if (q.size() > 0 && q[0].cyc == cyc) begin
      exp_t e;
      e = q.pop_front();
      chk("valid_w",         32'(wb.valid_w),         32'(e.valid));
      chk("address_error_w", 32'(wb.address_error_w), 32'(e.aerr));
      chk("write_enable",    32'(wb.write_enable),    32'(e.we));
      chk("retired_count",   32'(wb.retired_count),   32'(e.cnt));
      if (e.valid && e.known && !e.aerr) begin
        chk("write_address", 32'(wb.write_address), 32'(e.addr));
        chk("write_data",    wb.write_data,          e.data);
      end
    end
  end

  initial begin
    logic [CW-1:0] saved;
    checks = 0;
    errors = 0;
    reset = 1'b1;
    wb.stall = 0; wb.flush = 0; wb.valid_m = 0; wb.reg_write_m = 0; wb.mem_to_reg_m = 0;
    wb.load_type_m = 0; wb.byte_offset_m = 0; wb.write_address_m = 0; wb.alu_result_m = 0;
    wb.mem_read_data_m = 0; wb.rt_value_m = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid_w", 32'(wb.valid_w), 32'd0);
    chk("rst_we",      32'(wb.write_enable), 32'd0);
    chk("rst_data",    wb.write_data, 32'd0);
    chk("rst_count",   32'(wb.retired_count), 32'd0);
    reset = 1'b0;

    alu_op(5'd5, 32'h12345678);
    chk("alu_we",    32'(wb.write_enable),  32'd1);
    chk("alu_addr",  32'(wb.write_address), 32'd5);
    chk("alu_data",  wb.write_data,         32'h12345678);
    chk("alu_count", 32'(wb.retired_count), 32'd1);

    load_op(3'd1, 2'd0, 32'h80FF7F01, 32'h0);  chk("lb_off0",  wb.write_data, 32'hFFFFFF80);
    load_op(3'd2, 2'd1, 32'h80FF7F01, 32'h0);  chk("lbu_off1", wb.write_data, 32'h000000FF);
    load_op(3'd3, 2'd2, 32'h80FF7F01, 32'h0);  chk("lh_off2",  wb.write_data, 32'h00007F01);
    load_op(3'd4, 2'd0, 32'h80FF7F01, 32'h0);  chk("lhu_off0", wb.write_data, 32'h000080FF);
    load_op(3'd5, 2'd1, 32'hAABBCCDD, 32'h11223344);  chk("lwl_off1", wb.write_data, 32'hBBCCDD44);
    load_op(3'd6, 2'd1, 32'hAABBCCDD, 32'h11223344);  chk("lwr_off1", wb.write_data, 32'h1122AABB);
    load_op(3'd5, 2'd0, 32'hAABBCCDD, 32'h11223344);  chk("lwl_off0", wb.write_data, 32'hAABBCCDD);
    load_op(3'd6, 2'd3, 32'hAABBCCDD, 32'h11223344);  chk("lwr_off3", wb.write_data, 32'hAABBCCDD);
    chk("loads_count", 32'(wb.retired_count), 32'd9);

    saved = m_cnt;
    load_op(3'd0, 2'd2, 32'hDEADBEEF, 32'h0);
    chk("lw_mis_aerr",  32'(wb.address_error_w), 32'd1);
    chk("lw_mis_we",    32'(wb.write_enable),    32'd0);
    chk("lw_mis_count", 32'(wb.retired_count),   32'(saved));

    saved = m_cnt;
    alu_op(5'd0, 32'h55AA55AA);
    chk("r0_we",    32'(wb.write_enable),  32'd0);
    chk("r0_valid", 32'(wb.valid_w),       32'd1);
    chk("r0_count", 32'(wb.retired_count), 32'(saved + 1'b1));

    alu_op(5'd9, 32'hCAFEBABE);
    saved = m_cnt;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 5'd3, $urandom, $urandom, $urandom, 1'b1, 1'b0);
      chk("stall_data",  wb.write_data, 32'hCAFEBABE);
      chk("stall_addr",  32'(wb.write_address), 32'd9);
      chk("stall_count", 32'(wb.retired_count), 32'(saved));
    end

    step(1'b1, 1'b1, 1'b0, 3'd0, 2'd0, 5'd4, 32'h1, 32'h0, 32'h0, 1'b1, 1'b1);
    chk("flush_valid", 32'(wb.valid_w),      32'd0);
    chk("flush_we",    32'(wb.write_enable), 32'd0);

    // Asynchronous reset between edges while a write is pending.
    alu_op(5'd12, 32'h0BADF00D);
    chk("pre_rst_we", 32'(wb.write_enable), 32'd1);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("arst_we",    32'(wb.write_enable),    32'd0);
    chk("arst_valid", 32'(wb.valid_w),         32'd0);
    chk("arst_aerr",  32'(wb.address_error_w), 32'd0);
    chk("arst_addr",  32'(wb.write_address),   32'd0);
    chk("arst_data",  wb.write_data,           32'd0);
    chk("arst_count", 32'(wb.retired_count),   32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();

    for (int i = 0; i < 700; i++) begin
      step($urandom_range(0, 9) != 0, $urandom_range(0, 7) != 0, 1'($urandom),
           3'($urandom), 2'($urandom), 5'($urandom), $urandom, $urandom, $urandom,
           $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0);
    end

    while (m_cnt != {CW{1'b1}}) alu_op(5'd1, $urandom);
    chk("count_max", 32'(wb.retired_count), 32'((1 << CW) - 1));
    alu_op(5'd1, 32'h00000042);
    chk("count_wrap", 32'(wb.retired_count), 32'd0);

    @(negedge clk);
    #1;
    chk("sb_drained", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/writeback_stage.md
# writeback_stage

MEM/WB pipeline register and load-result formatter for the pipelined MIPS core. Captures memory-stage results on the rising clock edge, extracts and extends load data (LB/LBU/LH/LHU/LW/LWL/LWR, big-endian), and drives the register file write port. The register file commits writes on the falling edge in pipelined mode, so W-stage outputs stay stable for the whole cycle. Also keeps a retired-instruction counter.

## Interface
Parameters:
- COUNT_WIDTH, 32, width of retired_count

Ports:
- clk  in  1  core clock; all state updates on posedge
- reset  in  1  asynchronous, active-high; clears all state
- stall  in  1  hold W register contents
- flush  in  1  load a bubble into W (overrides stall)
- valid_m  in  1  M-stage instruction valid
- reg_write_m  in  1  instruction writes a GPR
- mem_to_reg_m  in  1  1 = result from memory, 0 = alu_result_m
- load_type_m  in  3  0 LW, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LWL, 6 LWR, 7 reserved (treated as LW)
- byte_offset_m  in  2  effective address [1:0]
- write_address_m  in  5  destination register
- alu_result_m  in  32  ALU/link result
- mem_read_data_m  in  32  aligned memory word, valid in the M cycle
- rt_value_m  in  32  old rt value, merged by LWL/LWR
- write_enable  out  1  to register file
- write_address  out  5  to register file
- write_data  out  32  to register file; also the W-stage forwarding source
- valid_w  out  1  W-stage entry valid
- address_error_w  out  1  misaligned load captured in W
- retired_count  out  COUNT_WIDTH  instructions committed since reset

## Operation
- Formatting is combinational in M: result_m is computed, then registered. W outputs come straight from flops, with no logic after the registers.
- mem_to_reg_m=0: result_m = alu_result_m, and load_type_m/byte_offset_m are ignored.
- Byte lanes: byte k occupies bits [31-8k : 24-8k], so offset 0 is the MSB.
- LB/LBU: byte at offset, sign-/zero-extended.
- LH/LHU: offset 0 gives [31:16], offset 2 gives [15:0]; sign-/zero-extended. Offset 1 or 3 is misaligned.
- LW: offset 0 only; any other offset is misaligned.
- LWL, offset k: result = (mem << 8k) | (rt & ((1<<8k)-1)).
- LWR, offset k: result = (mem >> 8(3-k)) | (rt & ~(32'hFFFFFFFF >> 8(3-k))).
- LWL/LWR are never misaligned.
- Misaligned load: address_error_w=1 and write_enable=0; write_data holds the formatted value, which is don't-care.
- write_enable = valid_w & reg_write_w & ~address_error_w & (write_address != 0).
- Register $0 is therefore never written.
- retired_count increments on a posedge only when all hold: stall=0, flush=0, valid_m=1, no misalignment. It wraps modulo 2^COUNT_WIDTH.

## Timing
- Latency: inputs sampled at posedge N appear on outputs after posedge N; the register file commits them at the following negedge.
- Register update priority per posedge: reset, then flush, then stall, then load.
  - flush: valid_w=0, address_error_w=0, write_enable=0. Other W fields are don't-care, implemented as cleared.
  - stall (flush=0): every W flop and retired_count hold.
- A repeated write of a stalled entry is permitted and harmless.
- Reset (asynchronous, any time including mid-stall): all outputs are 0 immediately. write_enable drops without waiting for a clock edge.
- Reset release: the first capture is at the first posedge with reset=0.
- No handshake. stall/flush come from the hazard unit and must be stable before posedge.

## Test plan
- Reset mid-operation: with valid_w=1 and write_enable=1, assert reset between edges -> all outputs 0 before the next posedge; retired_count=0.
- ALU op: valid_m=1, reg_write_m=1, mem_to_reg_m=0, alu_result_m=32'h12345678, write_address_m=5 -> next cycle write_enable=1, write_address=5, write_data=32'h12345678, retired_count=1.
- Loads with mem=32'h80FF7F01:
  - LB offset 0 -> 32'hFFFFFF80
  - LBU offset 1 -> 32'h000000FF
  - LH offset 2 -> 32'h00007F01
  - LHU offset 0 -> 32'h000080FF
- LWL/LWR with mem=32'hAABBCCDD, rt=32'h11223344:
  - LWL offset 1 -> 32'hBBCCDD44
  - LWR offset 1 -> 32'h1122AABB
  - LWL offset 0 and LWR offset 3 -> 32'hAABBCCDD
- Misaligned load and $0: LW offset 2 -> address_error_w=1, write_enable=0, count unchanged. reg_write_m=1 with write_address_m=0 -> write_enable=0, count increments.
- Stall/flush:
  - Stall 3 cycles with new inputs applied -> W outputs and count frozen.
  - flush=1 together with stall=1 -> valid_w=0 next cycle.
  - Count at 32'hFFFFFFFF plus one retire -> 0.
